// File: rtl/execute_stage.sv
// Execute stage: one shared ALU, a dedicated branch/jump target adder, and a single
// output register slice with valid/ready flow control toward the memory stage.

module alu (
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  input  logic [2:0]  i_Op,
  input  logic        i_Alt,
  output logic [31:0] o_Result,
  output logic        o_Zero,
  output logic        o_LessThan,
  output logic        o_LessThanUnsigned
);
  logic [31:0] w_result;
  logic [4:0]  w_shamt;

  assign w_shamt = i_B[4:0];

  // Op codes follow RV32 funct3; i_Alt selects SUB and SRA.
  always_comb begin
    w_result = 32'd0;
    case (i_Op)
      3'b000: w_result = i_Alt ? (i_A - i_B) : (i_A + i_B);
      3'b001: w_result = i_A << w_shamt;
      3'b010: w_result = {31'd0, $signed(i_A) < $signed(i_B)};
      3'b011: w_result = {31'd0, i_A < i_B};
      3'b100: w_result = i_A ^ i_B;
      3'b101: w_result = i_Alt ? ($signed(i_A) >>> w_shamt) : (i_A >> w_shamt);
      3'b110: w_result = i_A | i_B;
      3'b111: w_result = i_A & i_B;
      default: w_result = 32'd0;
    endcase
  end

  assign o_Result           = w_result;
  assign o_Zero             = (w_result == 32'd0);
  assign o_LessThan         = $signed(i_A) < $signed(i_B);
  assign o_LessThanUnsigned = i_A < i_B;
endmodule

module execute_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Flush,
  input  logic        i_Valid,
  output logic        o_Ready,
  input  logic [31:0] i_Pc,
  input  logic [31:0] i_Rs1Data,
  input  logic [31:0] i_Rs2Data,
  input  logic [31:0] i_Imm,
  input  logic        i_UseImm,
  input  logic        i_UsePcAsSrc1,
  input  logic [2:0]  i_AluOp,
  input  logic        i_AluOpAlt,
  input  logic        i_Branch,
  input  logic [2:0]  i_BranchFunct3,
  input  logic        i_Jump,
  input  logic        i_JumpReg,
  input  logic [4:0]  i_RdAddr,
  input  logic        i_RegWrite,
  output logic        o_Valid,
  input  logic        i_Ready,
  output logic [31:0] o_Result,
  output logic [31:0] o_StoreData,
  output logic [4:0]  o_RdAddr,
  output logic        o_RegWrite,
  output logic        o_Redirect,
  output logic [31:0] o_RedirectPc,
  output logic        o_Misaligned
);
  logic        r_valid;
  logic        r_redirect;
  logic        r_misaligned;
  logic        r_regwrite;
  logic [31:0] r_result;
  logic [31:0] r_store_data;
  logic [31:0] r_redirect_pc;
  logic [4:0]  r_rd_addr;

  logic        w_accept;
  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [2:0]  w_alu_op;
  logic        w_alu_alt;
  logic [31:0] w_alu_result;
  logic        w_zero;
  logic        w_lt;
  logic        w_ltu;
  logic        w_cond;
  logic        w_taken;
  logic [31:0] w_target_sum;
  logic [31:0] w_target;
  logic        w_misaligned;
  logic        w_regwrite;
  logic [31:0] w_link;

  // Handshake: a transfer happens on an edge where valid && ready are both high.
  // Upstream accept = i_Valid && o_Ready; downstream consume = o_Valid && i_Ready.
  // The slot frees when consumed, so a consume and an accept can share one edge.
  // A flush drops o_Ready and empties the slot regardless of i_Ready.
  assign o_Ready  = (!r_valid || i_Ready) && !i_Flush;
  assign w_accept = i_Valid && o_Ready;

  // Branches force a subtract of the raw register operands to produce compare flags.
  assign w_alu_a   = (i_UsePcAsSrc1 && !i_Branch) ? i_Pc  : i_Rs1Data;
  assign w_alu_b   = (i_UseImm && !i_Branch)      ? i_Imm : i_Rs2Data;
  assign w_alu_op  = i_Branch ? 3'b000 : i_AluOp;
  assign w_alu_alt = i_Branch ? 1'b1   : i_AluOpAlt;

  alu u_alu (
    .i_A                (w_alu_a),
    .i_B                (w_alu_b),
    .i_Op               (w_alu_op),
    .i_Alt              (w_alu_alt),
    .o_Result           (w_alu_result),
    .o_Zero             (w_zero),
    .o_LessThan         (w_lt),
    .o_LessThanUnsigned (w_ltu)
  );

  always_comb begin
    w_cond = 1'b0;
    case (i_BranchFunct3)
      3'b000:  w_cond = w_zero;
      3'b001:  w_cond = !w_zero;
      3'b100:  w_cond = w_lt;
      3'b101:  w_cond = !w_lt;
      3'b110:  w_cond = w_ltu;
      3'b111:  w_cond = !w_ltu;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken      = i_Jump || (i_Branch && w_cond);
  assign w_target_sum = (i_JumpReg ? i_Rs1Data : i_Pc) + i_Imm;
  assign w_target     = i_JumpReg ? (w_target_sum & ~32'h1) : w_target_sum;
  assign w_misaligned = w_taken && w_target[1];
  assign w_regwrite   = i_RegWrite && !i_Branch && (i_RdAddr != 5'd0) && !w_misaligned;
  assign w_link       = i_Pc + 32'd4;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_valid       <= 1'b0;
      r_redirect    <= 1'b0;
      r_misaligned  <= 1'b0;
      r_regwrite    <= 1'b0;
      r_result      <= 32'd0;
      r_store_data  <= 32'd0;
      r_rd_addr     <= 5'd0;
      r_redirect_pc <= RESET_VECTOR;
    end else begin
      r_redirect <= w_accept && w_taken;
      if (w_accept) begin
        r_valid      <= 1'b1;
        r_result     <= i_Jump ? w_link : w_alu_result;
        r_store_data <= i_Rs2Data;
        r_rd_addr    <= i_RdAddr;
        r_regwrite   <= w_regwrite;
        r_misaligned <= w_misaligned;
        if (w_taken) r_redirect_pc <= w_target;
      end else if (i_Flush || i_Ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_Valid      = r_valid;
  assign o_Result     = r_result;
  assign o_StoreData  = r_store_data;
  assign o_RdAddr     = r_rd_addr;
  assign o_RegWrite   = r_regwrite;
  assign o_Redirect   = r_redirect;
  assign o_RedirectPc = r_redirect_pc;
  assign o_Misaligned = r_misaligned;
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed scenarios plus a randomized stream checked
// against an arithmetic reference model and an expected-output queue.

module tb_execute_stage;
  localparam logic [31:0] RV = 32'h8000_0040;
  localparam int OW = 72;

  typedef struct packed {
    logic [31:0] pc, rs1, rs2, imm;
    logic        use_imm, use_pc;
    logic [2:0]  op;
    logic        alt, branch;
    logic [2:0]  f3;
    logic        jump, jreg;
    logic [4:0]  rd;
    logic        regwrite;
  } ins_t;

  typedef struct packed {
    logic [31:0] result;
    logic        regwrite, misaligned, taken;
    logic [31:0] target;
  } res_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] result, store;
    logic [4:0]  rd;
    logic        regwrite, misaligned;
  } out_t;

  logic        i_Clock = 0, i_Reset = 0, i_Flush = 0, i_Valid = 0, i_Ready = 0;
  logic [31:0] i_Pc = 0, i_Rs1Data = 0, i_Rs2Data = 0, i_Imm = 0;
  logic        i_UseImm = 0, i_UsePcAsSrc1 = 0, i_AluOpAlt = 0, i_Branch = 0;
  logic [2:0]  i_AluOp = 0, i_BranchFunct3 = 0;
  logic        i_Jump = 0, i_JumpReg = 0, i_RegWrite = 0;
  logic [4:0]  i_RdAddr = 0;
  logic        o_Ready, o_Valid, o_RegWrite, o_Redirect, o_Misaligned;
  logic [31:0] o_Result, o_StoreData, o_RedirectPc;
  logic [4:0]  o_RdAddr;

  int n_cmp = 0;
  int n_fail = 0;
  logic [OW-1:0] exp_q[$];

  execute_stage #(.RESET_VECTOR(RV)) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Flush(i_Flush), .i_Valid(i_Valid),
    .o_Ready(o_Ready), .i_Pc(i_Pc), .i_Rs1Data(i_Rs1Data), .i_Rs2Data(i_Rs2Data),
    .i_Imm(i_Imm), .i_UseImm(i_UseImm), .i_UsePcAsSrc1(i_UsePcAsSrc1),
    .i_AluOp(i_AluOp), .i_AluOpAlt(i_AluOpAlt), .i_Branch(i_Branch),
    .i_BranchFunct3(i_BranchFunct3), .i_Jump(i_Jump), .i_JumpReg(i_JumpReg),
    .i_RdAddr(i_RdAddr), .i_RegWrite(i_RegWrite), .o_Valid(o_Valid), .i_Ready(i_Ready),
    .o_Result(o_Result), .o_StoreData(o_StoreData), .o_RdAddr(o_RdAddr),
    .o_RegWrite(o_RegWrite), .o_Redirect(o_Redirect), .o_RedirectPc(o_RedirectPc),
    .o_Misaligned(o_Misaligned)
  );

  // Clock / reset block
  always #5 i_Clock = ~i_Clock;

  task automatic tick;
    @(posedge i_Clock);
    #1;
  endtask

  // Reference model: instruction semantics in plain arithmetic
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    int sh;
    sa = a;
    sh = int'(b % 32);
    case (op)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? 32'(sa >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic res_t model(input ins_t x);
    res_t r;
    r = '0;
    if (x.branch) begin
      r.result = x.rs1 - x.rs2;
      case (x.f3)
        3'd0: r.taken = (x.rs1 == x.rs2);
        3'd1: r.taken = (x.rs1 != x.rs2);
        3'd4: r.taken = ($signed(x.rs1) < $signed(x.rs2));
        3'd5: r.taken = ($signed(x.rs1) >= $signed(x.rs2));
        3'd6: r.taken = (x.rs1 < x.rs2);
        3'd7: r.taken = (x.rs1 >= x.rs2);
        default: r.taken = 1'b0;
      endcase
    end else begin
      r.result = alu_ref(x.op, x.alt, x.use_pc ? x.pc : x.rs1, x.use_imm ? x.imm : x.rs2);
    end
    if (x.jump) begin
      r.taken = 1'b1;
      r.result = x.pc + 32'd4;
    end
    r.target = x.jreg ? ((x.rs1 + x.imm) & 32'hFFFF_FFFE) : (x.pc + x.imm);
    r.misaligned = r.taken && r.target[1];
    r.regwrite = x.regwrite && !x.branch && (x.rd != 5'd0) && !r.misaligned;
    return r;
  endfunction

  function automatic out_t exp_out(input ins_t x);
    res_t r;
    out_t o;
    r = model(x);
    o.valid = 1'b1;
    o.result = r.result;
    o.store = x.rs2;
    o.rd = x.rd;
    o.regwrite = r.regwrite;
    o.misaligned = r.misaligned;
    return o;
  endfunction

  function automatic out_t obs();
    out_t o;
    o.valid = o_Valid;
    o.result = o_Result;
    o.store = o_StoreData;
    o.rd = o_RdAddr;
    o.regwrite = o_RegWrite;
    o.misaligned = o_Misaligned;
    return o;
  endfunction

  // Driver tasks
  task automatic drive(input ins_t x);
    i_Pc = x.pc; i_Rs1Data = x.rs1; i_Rs2Data = x.rs2; i_Imm = x.imm;
    i_UseImm = x.use_imm; i_UsePcAsSrc1 = x.use_pc; i_AluOp = x.op; i_AluOpAlt = x.alt;
    i_Branch = x.branch; i_BranchFunct3 = x.f3; i_Jump = x.jump; i_JumpReg = x.jreg;
    i_RdAddr = x.rd; i_RegWrite = x.regwrite;
  endtask

  function automatic ins_t rand_add();
    ins_t x;
    x = '0;
    x.rs1 = $urandom();
    x.rs2 = $urandom();
    x.rd = 5'($urandom_range(1, 31));
    x.regwrite = 1'b1;
    return x;
  endfunction

  function automatic logic [31:0] rand_val();
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 3));
    return $urandom();
  endfunction

  function automatic ins_t rand_ins();
    ins_t x;
    int kind;
    x = '0;
    kind = int'($urandom_range(0, 3));
    x.pc = $urandom() & 32'hFFFF_FFFC;
    x.rs1 = rand_val();
    x.rs2 = ($urandom_range(0, 3) == 0) ? x.rs1 : rand_val();
    x.imm = rand_val();
    x.use_imm = 1'($urandom_range(0, 1));
    x.use_pc = 1'($urandom_range(0, 1));
    x.op = 3'($urandom_range(0, 7));
    x.alt = 1'($urandom_range(0, 1));
    x.f3 = 3'($urandom_range(0, 7));
    x.rd = 5'($urandom_range(0, 31));
    x.regwrite = 1'($urandom_range(0, 1));
    if (kind == 2) x.branch = 1'b1;
    if (kind == 3) begin
      x.jump = 1'b1;
      x.jreg = 1'($urandom_range(0, 1));
    end
    return x;
  endfunction

  task automatic test_reset;
    i_Reset = 1; i_Valid = 1; i_Ready = 1; drive(rand_add());
    tick;
    i_Reset = 0; i_Valid = 0;
    n_cmp++;
    if (obs() !== out_t'(0) || o_Redirect !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %h/%b required 0/0", obs(), o_Redirect);
    end
    n_cmp++;
    if (o_RedirectPc !== RV) begin
      n_fail++; $display("FAIL reset_pc: got %h required %h", o_RedirectPc, RV);
    end
  endtask

  task automatic test_add;
    ins_t x;
    x = '0; x.rs1 = 7; x.rs2 = 5; x.rd = 3; x.regwrite = 1;
    i_Ready = 1; drive(x); i_Valid = 1;
    tick;
    i_Valid = 0;
    n_cmp++;
    if ({o_Valid, o_Result, o_RdAddr, o_RegWrite, o_Redirect} !== {1'b1, 32'd12, 5'd3, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL add: got v=%b r=%h rd=%0d we=%b redir=%b required 1/0000000c/3/1/0",
                         o_Valid, o_Result, o_RdAddr, o_RegWrite, o_Redirect);
    end
    tick;
    n_cmp++;
    if (o_Valid !== 1'b0) begin n_fail++; $display("FAIL add_drain: got %b required 0", o_Valid); end
  endtask

  task automatic test_branch;
    ins_t x;
    x = '0; x.branch = 1; x.f3 = 3'd4; x.pc = 32'h100; x.rs1 = 32'hFFFF_FFFF; x.rs2 = 1;
    x.imm = 32'h20; x.rd = 5; x.regwrite = 1; x.op = 3'd6; x.use_imm = 1;
    i_Ready = 1; drive(x); i_Valid = 1;
    tick;
    i_Valid = 0;
    n_cmp++;
    if ({o_Redirect, o_RedirectPc, o_RegWrite, o_Result} !== {1'b1, 32'h120, 1'b0, 32'hFFFF_FFFE}) begin
      n_fail++; $display("FAIL blt: got redir=%b pc=%h we=%b res=%h required 1/00000120/0/fffffffe",
                         o_Redirect, o_RedirectPc, o_RegWrite, o_Result);
    end
    x.f3 = 3'd6;
    drive(x); i_Valid = 1;
    tick;
    i_Valid = 0;
    n_cmp++;
    if ({o_Redirect, o_RedirectPc, o_Valid} !== {1'b0, 32'h120, 1'b1}) begin
      n_fail++; $display("FAIL bltu: got redir=%b pc=%h v=%b required 0/00000120/1",
                         o_Redirect, o_RedirectPc, o_Valid);
    end
    tick;
  endtask

  task automatic test_jump;
    ins_t x;
    x = '0; x.jump = 1; x.jreg = 1; x.pc = 32'h200; x.rs1 = 32'h1003; x.rd = 1; x.regwrite = 1;
    i_Ready = 1; drive(x); i_Valid = 1;
    tick;
    n_cmp++;
    if ({o_Redirect, o_RedirectPc, o_Misaligned, o_RegWrite, o_Result} !==
        {1'b1, 32'h1002, 1'b1, 1'b0, 32'h204}) begin
      n_fail++; $display("FAIL jalr: got redir=%b pc=%h mis=%b we=%b res=%h required 1/00001002/1/0/00000204",
                         o_Redirect, o_RedirectPc, o_Misaligned, o_RegWrite, o_Result);
    end
    x.jreg = 0; x.pc = 32'hFFFF_FFFC; x.imm = 32'h8;
    drive(x);
    tick;
    i_Valid = 0;
    n_cmp++;
    if ({o_Redirect, o_RedirectPc, o_Misaligned, o_RegWrite, o_Result} !==
        {1'b1, 32'h4, 1'b0, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL jal_wrap: got redir=%b pc=%h mis=%b we=%b res=%h required 1/00000004/0/1/00000000",
                         o_Redirect, o_RedirectPc, o_Misaligned, o_RegWrite, o_Result);
    end
    tick;
  endtask

  task automatic test_stall;
    ins_t a, b;
    i_Ready = 1; a = rand_add(); drive(a); i_Valid = 1;
    tick;
    b = rand_add(); drive(b); i_Ready = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (o_Ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b required 0", o_Ready); end
      tick;
      n_cmp++;
      if (obs() !== exp_out(a)) begin
        n_fail++; $display("FAIL stall_hold: got %h required %h", obs(), exp_out(a));
      end
    end
    i_Ready = 1;
    #1;
    n_cmp++;
    if (o_Ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b required 1", o_Ready); end
    for (int i = 0; i < 4; i++) begin
      tick;
      n_cmp++;
      if (obs() !== exp_out(b)) begin
        n_fail++; $display("FAIL back_to_back%0d: got %h required %h", i, obs(), exp_out(b));
      end
      b = rand_add(); drive(b);
    end
    i_Valid = 0;
    tick;
  endtask

  task automatic test_flush;
    ins_t x;
    x = '0; x.branch = 1; x.f3 = 3'd0; x.rs1 = 9; x.rs2 = 9; x.pc = 32'h300; x.imm = 32'h40;
    i_Ready = 1; i_Valid = 0; tick;
    drive(x); i_Valid = 1; i_Flush = 1;
    #1;
    n_cmp++;
    if (o_Ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b required 0", o_Ready); end
    tick;
    i_Flush = 0;
    n_cmp++;
    if ({o_Valid, o_Redirect} !== 2'b00) begin
      n_fail++; $display("FAIL flush_block: got v=%b redir=%b required 0/0", o_Valid, o_Redirect);
    end
    tick;
    i_Valid = 0;
    n_cmp++;
    if ({o_Valid, o_Redirect, o_RedirectPc} !== {2'b11, 32'h340}) begin
      n_fail++; $display("FAIL beq_taken: got v=%b redir=%b pc=%h required 1/1/00000340",
                         o_Valid, o_Redirect, o_RedirectPc);
    end
    i_Flush = 1; i_Ready = 0;
    #1;
    n_cmp++;
    if (o_Redirect !== 1'b1) begin n_fail++; $display("FAIL flush_pulse_kept: got %b required 1", o_Redirect); end
    tick;
    i_Flush = 0;
    n_cmp++;
    if ({o_Valid, o_Redirect} !== 2'b00) begin
      n_fail++; $display("FAIL flush_stalled: got v=%b redir=%b required 0/0", o_Valid, o_Redirect);
    end
  endtask

  task automatic test_reset_stall;
    ins_t x;
    x = '0; x.jump = 1; x.pc = 32'h400; x.imm = 32'h10; x.rd = 2; x.regwrite = 1;
    i_Ready = 1; drive(x); i_Valid = 1;
    tick;
    i_Ready = 0; i_Valid = 0;
    tick;
    n_cmp++;
    if ({o_Valid, o_Result, o_RedirectPc} !== {1'b1, 32'h404, 32'h410}) begin
      n_fail++; $display("FAIL pre_reset: got v=%b res=%h pc=%h required 1/00000404/00000410",
                         o_Valid, o_Result, o_RedirectPc);
    end
    i_Reset = 1; i_Valid = 1; drive(rand_add());
    tick;
    i_Reset = 0; i_Valid = 0;
    n_cmp++;
    if (obs() !== out_t'(0) || o_Redirect !== 1'b0 || o_RedirectPc !== RV) begin
      n_fail++; $display("FAIL reset_stall: got %h/%b/%h required 0/0/%h", obs(), o_Redirect, o_RedirectPc, RV);
    end
  endtask

  task automatic test_random;
    ins_t x;
    res_t r;
    logic [31:0] exp_rpc;
    logic exp_redir, exp_rdy, acc;
    i_Reset = 1; i_Valid = 0; i_Flush = 0;
    tick;
    i_Reset = 0;
    exp_q.delete();
    exp_rpc = RV;
    for (int c = 0; c < 400; c++) begin
      x = rand_ins(); drive(x);
      i_Valid = ($urandom_range(0, 9) < 7);
      i_Ready = ($urandom_range(0, 3) != 0);
      i_Flush = ($urandom_range(0, 15) == 0);
      #1;
      exp_rdy = (exp_q.size() == 0 || i_Ready) && !i_Flush;
      n_cmp++;
      if (o_Ready !== exp_rdy) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b required %b", c, o_Ready, exp_rdy);
      end
      acc = i_Valid && exp_rdy;
      r = model(x);
      if (acc) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_q.push_back(exp_out(x));
        if (r.taken) exp_rpc = r.target;
      end else if (i_Flush || i_Ready) begin
        exp_q.delete();
      end
      exp_redir = acc && r.taken;
      tick;
      n_cmp++;
      if (exp_q.size() == 0) begin
        if (o_Valid !== 1'b0) begin
          n_fail++; $display("FAIL rand_empty[%0d]: got v=%b required 0", c, o_Valid);
        end
      end else if (obs() !== out_t'(exp_q[0])) begin
        n_fail++; $display("FAIL rand_out[%0d]: got %h required %h", c, obs(), exp_q[0]);
      end
      n_cmp++;
      if ({o_Redirect, o_RedirectPc} !== {exp_redir, exp_rpc}) begin
        n_fail++; $display("FAIL rand_redirect[%0d]: got %b/%h required %b/%h",
                           c, o_Redirect, o_RedirectPc, exp_redir, exp_rpc);
      end
    end
    i_Valid = 0; i_Flush = 0;
  endtask

  initial begin
    test_reset;
    test_add;
    test_branch;
    test_jump;
    test_stall;
    test_flush;
    test_reset_stall;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter: RESET_VECTOR, 32'h0000_0000, value loaded into o_RedirectPc on reset.
REQ-002 Ports, one per line, as follows; all buses are unsigned unless stated.
- i_Clock  in  1  sole clock; all state updates on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Flush  in  1  kill in-flight instruction from a later stage.
- i_Valid  in  1  decode presents an instruction.
- o_Ready  out 1  stage can accept this cycle.
- i_Pc, i_Rs1Data, i_Rs2Data, i_Imm  in  32 each  instruction PC, operands, sign-extended immediate.
- i_UseImm, i_UsePcAsSrc1  in  1 each  ALU source-2 = imm; ALU source-1 = PC.
- i_AluOp, i_AluOpAlt  in  3, 1  ALU operation code and alternate bit, as encoded for alu.
- i_Branch, i_BranchFunct3  in  1, 3  conditional branch and its funct3.
- i_Jump, i_JumpReg  in  1 each  JAL; JALR (i_JumpReg implies i_Jump).
- i_RdAddr, i_RegWrite  in  5, 1  destination register and write enable.
- o_Valid  out 1  result register holds a live instruction.
- i_Ready  in  1  memory stage accepts o_* this cycle.
- o_Result, o_StoreData  out 32 each  ALU/link result; registered i_Rs2Data.
- o_RdAddr, o_RegWrite  out 5, 1  registered destination and write enable.
- o_Redirect, o_RedirectPc  out 1, 32  one-cycle fetch redirect pulse and target.
- o_Misaligned  out 1  taken target has bit 1 set; registered with the instruction.

Function
REQ-003 Stage SHALL instantiate alu once; no second ALU.
REQ-004 o_Ready SHALL equal (!o_Valid || i_Ready) && !i_Flush, combinationally.
REQ-005 Accept SHALL occur when i_Valid && o_Ready; accepted fields are registered into o_* at that edge.
REQ-006 If o_Valid && !i_Ready, all o_* except o_Redirect SHALL hold unchanged.
REQ-007 If o_Valid && i_Ready && no accept, o_Valid SHALL clear next cycle.
REQ-008 ALU source-1 SHALL be i_Pc if i_UsePcAsSrc1 else i_Rs1Data; source-2 SHALL be i_Imm if i_UseImm else i_Rs2Data.
REQ-009 For i_Branch, ALU SHALL be driven ADD with alt=1 on rs1, rs2 (subtract) irrespective of i_AluOp; condition from ALU flags: 000 Zero, 001 !Zero, 100 LessThan, 101 !LessThan, 110 LessThanUnsigned, 111 !LessThanUnsigned; 010/011 never taken.
REQ-010 A separate 32-bit adder SHALL compute target = i_Pc + i_Imm (branch, JAL) or (i_Rs1Data + i_Imm) & ~32'h1 (JALR); carry out discarded (wrap-around at 2^32).
REQ-011 For i_Jump, o_Result SHALL be i_Pc + 4 (wrapping); otherwise the ALU output.
REQ-012 On accept of a taken branch or any jump, o_Redirect SHALL be 1 for exactly the next cycle with o_RedirectPc = target; o_RedirectPc holds its last value otherwise.
REQ-013 o_Misaligned SHALL be target[1] for taken control transfers, else 0; when set, o_RegWrite SHALL be registered as 0.
REQ-014 Branches SHALL register o_RegWrite = 0 regardless of i_RegWrite; i_RdAddr = 0 SHALL register o_RegWrite = 0.
REQ-015 Not-taken branches SHALL produce no redirect.
REQ-016 i_Flush SHALL clear o_Valid next cycle, block accept, and suppress any redirect that would arise from the same edge; flush wins over simultaneous accept and i_Ready.
REQ-017 Redirect pulse already asserted SHALL not be cancelled by a flush arriving in its own cycle.
REQ-018 Latency: one cycle input-to-output; back-to-back accepts SHALL sustain one instruction per cycle when i_Ready is 1.

Reset
REQ-019 While i_Reset is 1 at an edge: o_Valid=0, o_Redirect=0, o_Misaligned=0, o_RegWrite=0, o_Result=0, o_StoreData=0, o_RdAddr=0, o_RedirectPc=RESET_VECTOR; no accept occurs that cycle.
REQ-020 Reset SHALL override flush, accept and stall; an instruction held mid-stall is discarded.

Verification
REQ-021 ADD rs1=7, rs2=5, rd=3, i_Ready=1 -> next cycle o_Valid=1, o_Result=12, o_RdAddr=3, o_RegWrite=1, o_Redirect=0.
REQ-022 BLT pc=0x100, rs1=0xFFFF_FFFF, rs2=1, imm=0x20 -> o_Redirect pulse 1 cycle, o_RedirectPc=0x120, o_RegWrite=0; same with BLTU -> no redirect.
REQ-023 JALR pc=0x200, rs1=0x1003, imm=0, rd=1 -> o_RedirectPc=0x1002, o_Misaligned=1, o_RegWrite=0; JAL pc=0xFFFF_FFFC -> o_Result=0.
REQ-024 i_Ready=0 for 3 cycles with i_Valid=1 held -> o_Ready=0, o_* frozen; i_Ready=1 -> next instruction accepted, one per cycle thereafter.
REQ-025 Taken BEQ (rs1=rs2=9) accepted with i_Flush=1 same cycle -> no accept, o_Valid=0, o_Redirect=0 next cycle.
REQ-026 i_Reset=1 while o_Valid=1 and stalled -> next cycle o_Valid=0, o_RedirectPc=RESET_VECTOR, all other outputs 0.
